// File: rtl/kbd_pkg.sv
// Shared keyboard event types: packed event record and typematic repeat FSM states.
package kbd_pkg;

    localparam int KEY_CODE_W = 9;
    localparam int KEY_EVT_W  = 11;

    typedef struct packed {
        logic [KEY_CODE_W-1:0] code;
        logic                  make;
        logic                  rpt;
    } key_evt_t;

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_DELAY,
        RPT_REPEAT
    } rpt_state_t;

    function automatic key_evt_t mk_evt(input logic [KEY_CODE_W-1:0] code,
                                        input logic make, input logic rpt);
        key_evt_t e;
        e.code = code;
        e.make = make;
        e.rpt  = rpt;
        return e;
    endfunction

endpackage

// File: rtl/key_evt_fifo.sv
// Synchronous first-word fall-through FIFO; a push into a full FIFO is taken
// when a pop happens in the same cycle.
module key_evt_fifo
    import kbd_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = KEY_EVT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] COUNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == COUNT_FULL);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Head is gated so the outputs read zero whenever nothing is queued.
    assign head = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/key_event_scheduler.sv
// Captures decoder make/break events, adds typematic repeats for the most
// recently pressed key, and queues everything for a single valid/ready consumer.
module key_event_scheduler
    import kbd_pkg::*;
#(
    parameter int DEPTH         = 8,
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 10_000_000,
    parameter int CNT_W         = 26
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      key_valid,
    input  logic [KEY_CODE_W-1:0]     last_change,
    input  logic [2**KEY_CODE_W-1:0]  key_down,
    input  logic                      evt_ready,
    output logic                      evt_valid,
    output logic [KEY_CODE_W-1:0]     evt_code,
    output logic                      evt_make,
    output logic                      evt_repeat,
    output logic                      overflow,
    input  logic                      ovf_clr
);

    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    rpt_state_t             state, state_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic [KEY_CODE_W-1:0]  rpt_code, rpt_code_nxt;

    logic                   capture;
    logic                   cap_make;
    logic                   rpt_held;
    logic                   rpt_break;
    logic                   tick;
    logic                   pop;
    logic                   push;
    logic                   push_ok;
    logic                   fifo_full;
    logic                   fifo_empty;
    key_evt_t               push_evt;
    key_evt_t               head_evt;
    logic [KEY_EVT_W-1:0]   head_bits;

    assign capture   = key_valid && en;
    assign cap_make  = key_down[last_change];
    assign rpt_held  = key_down[rpt_code];
    assign rpt_break = capture && !cap_make && (last_change == rpt_code);
    assign pop       = evt_valid && evt_ready;
    assign push_ok   = !fifo_full || pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RPT_IDLE;
            cnt      <= '0;
            rpt_code <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            rpt_code <= rpt_code_nxt;
        end
    end

    // Any captured make retargets the repeat onto the newest key.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        rpt_code_nxt = rpt_code;
        tick         = 1'b0;
        if (!en) begin
            state_nxt = RPT_IDLE;
            cnt_nxt   = '0;
        end else if (capture && cap_make) begin
            state_nxt    = RPT_DELAY;
            cnt_nxt      = '0;
            rpt_code_nxt = last_change;
        end else begin
            case (state)
                RPT_DELAY, RPT_REPEAT: begin
                    if (!rpt_held || rpt_break) begin
                        state_nxt = RPT_IDLE;
                        cnt_nxt   = '0;
                    end else if (cnt == ((state == RPT_DELAY) ? DELAY_LAST : PERIOD_LAST)) begin
                        tick      = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = RPT_REPEAT;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                default: begin
                    state_nxt = RPT_IDLE;
                end
            endcase
        end
    end

    // A real key event always wins the single push slot over a repeat tick.
    always_comb begin
        push     = capture || tick;
        push_evt = capture ? mk_evt(last_change, cap_make, 1'b0)
                           : mk_evt(rpt_code, 1'b1, 1'b1);
    end

    key_evt_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (KEY_EVT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_evt),
        .pop       (pop),
        .head      (head_bits),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      overflow <= 1'b0;
        else if (capture && !push_ok) overflow <= 1'b1;
        else if (ovf_clr)             overflow <= 1'b0;
    end

    assign head_evt   = key_evt_t'(head_bits);
    assign evt_valid  = !fifo_empty;
    assign evt_code   = head_evt.code;
    assign evt_make   = head_evt.make;
    assign evt_repeat = head_evt.rpt;

endmodule
